// File: rtl/chip8_fetch_sequencer.sv
// Chip8 fetch/sequencing stage: owns the PC and call stack, assembles 16-bit
// instructions from byte-wide program memory and steps CONTROL for Fx55/Fx65.
module chip8_fetch_sequencer #(
    parameter logic [11:0] PC_RESET    = 12'h200,
    parameter int          STACK_DEPTH = 16
) (
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic        run,
    output logic [11:0] mem_addr,
    input  logic [7:0]  mem_readdata,
    output logic [15:0] instruction,
    output logic [3:0]  CONTROL,
    output logic [11:0] PC_readdata,
    input  logic        PC_WE,
    input  logic [11:0] PC_writedata,
    output logic        exec_strobe,
    output logic        stack_error,
    output logic        halted,
    output logic [2:0]  state_dbg
);

    localparam int SIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SPW = SIW + 1;

    typedef enum logic [2:0] {
        S_FETCH_HI = 3'd0,
        S_FETCH_LO = 3'd1,
        S_LATCH    = 3'd2,
        S_EXECUTE  = 3'd3,
        S_MULTI    = 3'd4,
        S_HALT     = 3'd5
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [11:0]     pc;
    logic [SPW-1:0]  sp;
    logic [15:0]     ir;
    logic [3:0]      control;
    logic [11:0]     stack [STACK_DEPTH];

    logic            is_ret;
    logic            is_call;
    logic            is_multi;
    logic            stack_empty;
    logic            stack_full;
    logic [SIW-1:0]  push_idx;
    logic [SIW-1:0]  pop_idx;

    assign is_ret      = (ir == 16'h00EE);
    assign is_call     = (ir[15:12] == 4'h2);
    assign is_multi    = (ir[15:12] == 4'hF) && ((ir[7:0] == 8'h55) || (ir[7:0] == 8'h65));
    assign stack_empty = (sp == '0);
    assign stack_full  = (sp == SPW'(STACK_DEPTH));
    assign push_idx    = SIW'(sp);
    assign pop_idx     = SIW'(sp - SPW'(1));

    // State register
    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH_HI;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a stack fault in EXECUTE parks the block in HALT
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH_HI: if (run) state_nxt = S_FETCH_LO;
            S_FETCH_LO: state_nxt = S_LATCH;
            S_LATCH:    state_nxt = S_EXECUTE;
            S_EXECUTE: begin
                if (is_ret && stack_empty) begin
                    state_nxt = S_HALT;
                end else if (is_call && stack_full) begin
                    state_nxt = S_HALT;
                end else if (is_multi) begin
                    state_nxt = S_MULTI;
                end else begin
                    state_nxt = S_FETCH_HI;
                end
            end
            S_MULTI:    if (control == ir[11:8]) state_nxt = S_FETCH_HI;
            S_HALT:     state_nxt = S_HALT;
            default:    state_nxt = S_FETCH_HI;
        endcase
    end

    // Outputs; the instruction is only visible during its execute slot(s)
    always_comb begin
        mem_addr    = pc;
        instruction = 16'h0000;
        exec_strobe = 1'b0;
        halted      = 1'b0;
        case (state)
            S_FETCH_LO: mem_addr = pc + 12'd1;
            S_EXECUTE: begin
                instruction = ir;
                exec_strobe = 1'b1;
            end
            S_MULTI:    instruction = ir;
            S_HALT:     halted = 1'b1;
            default: ;
        endcase
    end

    assign CONTROL     = control;
    assign PC_readdata = pc;
    assign state_dbg   = state;

    // Datapath: instruction bytes, PC, stack pointer, CONTROL and the sticky fault
    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            pc          <= PC_RESET;
            sp          <= '0;
            ir          <= 16'h0000;
            control     <= 4'd0;
            stack_error <= 1'b0;
        end else begin
            case (state)
                S_FETCH_LO: ir[15:8] <= mem_readdata;
                S_LATCH: begin
                    ir[7:0] <= mem_readdata;
                    pc      <= pc + 12'd2;
                end
                S_EXECUTE: begin
                    control <= 4'd0;
                    if (is_ret) begin
                        if (stack_empty) begin
                            stack_error <= 1'b1;
                        end else begin
                            sp <= sp - SPW'(1);
                            pc <= stack[pop_idx];
                        end
                    end else if (is_call) begin
                        if (stack_full) begin
                            stack_error <= 1'b1;
                        end else begin
                            sp <= sp + SPW'(1);
                            pc <= ir[11:0];
                        end
                    end else if (PC_WE) begin
                        pc <= PC_writedata;
                    end
                end
                S_MULTI: control <= (control == ir[11:8]) ? 4'd0 : control + 4'd1;
                default: ;
            endcase
        end
    end

    // Stack storage needs no reset: sp alone defines which entries are live
    always_ff @(posedge cpu_clk) begin
        if (state == S_EXECUTE && is_call && !stack_full) begin
            stack[push_idx] <= pc;
        end
    end

endmodule

// File: tb/tb_chip8_fetch_sequencer.sv
// Bench for chip8_fetch_sequencer: instruction-level model builds per-cycle
// expectations into exp_q; a negedge process compares every cycle.
module tb_chip8_fetch_sequencer;

  logic        cpu_clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic [11:0] mem_addr;
  logic [7:0]  mem_readdata = 8'h00;
  logic [15:0] instruction;
  logic [3:0]  CONTROL;
  logic [11:0] PC_readdata;
  logic        PC_WE = 1'b0;
  logic [11:0] PC_writedata = 12'h000;
  logic        exec_strobe;
  logic        stack_error;
  logic        halted;
  logic [2:0]  state_dbg;

  chip8_fetch_sequencer dut (
    .cpu_clk      (cpu_clk),
    .reset        (reset),
    .run          (run),
    .mem_addr     (mem_addr),
    .mem_readdata (mem_readdata),
    .instruction  (instruction),
    .CONTROL      (CONTROL),
    .PC_readdata  (PC_readdata),
    .PC_WE        (PC_WE),
    .PC_writedata (PC_writedata),
    .exec_strobe  (exec_strobe),
    .stack_error  (stack_error),
    .halted       (halted),
    .state_dbg    (state_dbg)
  );

  // clock / reset block and synchronous program memory
  always #5 cpu_clk = ~cpu_clk;

  logic [7:0] mem [4096];
  always @(posedge cpu_clk) mem_readdata <= mem[mem_addr];

  int errors = 0;
  int checks = 0;

  // expectation record: {chk_addr, mem_addr, pc, instruction, control, strobe, err, halted}
  logic [47:0] exp_q[$];
  logic [47:0] cur;
  bit          chk_en = 1'b0;

  // instruction-level reference model
  logic [11:0] m_pc;
  int          m_sp;
  logic [11:0] m_stack [16];
  logic        m_err;
  logic        m_halt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t state_dbg=%0d)", name, act, exp, $time, state_dbg);
    end
  endtask

  function automatic logic [47:0] mk(input logic ac, input logic [11:0] a, input logic [11:0] p,
                                     input logic [15:0] i, input logic [3:0] c, input logic s,
                                     input logic e, input logic h);
    return {ac, a, p, i, c, s, e, h};
  endfunction

  // scoreboard: one expectation per cycle, sampled on the falling edge
  always @(negedge cpu_clk) begin
    if (chk_en && exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      if (cur[47]) check("mem_addr", 32'(mem_addr), 32'(cur[46:35]));
      check("pc_readdata", 32'(PC_readdata), 32'(cur[34:23]));
      check("instruction", 32'(instruction), 32'(cur[22:7]));
      check("control", 32'(CONTROL), 32'(cur[6:3]));
      check("exec_strobe", 32'(exec_strobe), 32'(cur[2]));
      check("stack_error", 32'(stack_error), 32'(cur[1]));
      check("halted", 32'(halted), 32'(cur[0]));
    end
  end

  // driver tasks
  task automatic step(input logic [47:0] e);
    exp_q.push_back(e);
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic noise();
    PC_WE = 1'($urandom_range(0, 1));
    PC_writedata = 12'($urandom);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    reset = 1'b1;
    #2;
    check("rst_mem_addr", 32'(mem_addr), 32'h200);
    check("rst_pc", 32'(PC_readdata), 32'h200);
    check("rst_instruction", 32'(instruction), 32'h0);
    check("rst_control", 32'(CONTROL), 32'h0);
    check("rst_exec_strobe", 32'(exec_strobe), 32'h0);
    check("rst_stack_error", 32'(stack_error), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    @(posedge cpu_clk);
    #1;
    reset = 1'b0;
    m_pc = 12'h200;
    m_sp = 0;
    m_err = 1'b0;
    m_halt = 1'b0;
    chk_en = 1'b1;
  endtask

  // run_mode: 0 run held high, 1 random run, 2 run dropped after the fetch starts
  task automatic run_instr(input logic [15:0] ins, input int run_mode, input logic we,
                           input logic [11:0] wd, input int abort_at);
    logic [11:0] a1;
    bit go;
    bit multi;
    a1 = m_pc + 12'd1;
    mem[m_pc] = ins[15:8];
    mem[a1] = ins[7:0];
    go = 1'b0;
    while (!go) begin
      go = (run_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      run = go;
      noise();
      step(mk(1'b1, m_pc, m_pc, 16'h0, 4'h0, 1'b0, m_err, 1'b0));
    end
    run = (run_mode == 2) ? 1'b0 : ((run_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1);
    noise();
    step(mk(1'b1, a1, m_pc, 16'h0, 4'h0, 1'b0, m_err, 1'b0));
    noise();
    step(mk(1'b0, 12'h0, m_pc, 16'h0, 4'h0, 1'b0, m_err, 1'b0));
    m_pc = m_pc + 12'd2;
    PC_WE = we;
    PC_writedata = wd;
    step(mk(1'b0, 12'h0, m_pc, ins, 4'h0, 1'b1, m_err, 1'b0));
    if (ins == 16'h00EE) begin
      if (m_sp == 0) begin
        m_err = 1'b1;
        m_halt = 1'b1;
      end else begin
        m_sp--;
        m_pc = m_stack[m_sp];
      end
    end else if (ins[15:12] == 4'h2) begin
      if (m_sp == 16) begin
        m_err = 1'b1;
        m_halt = 1'b1;
      end else begin
        m_stack[m_sp] = m_pc;
        m_sp++;
        m_pc = ins[11:0];
      end
    end else if (we) begin
      m_pc = wd;
    end
    multi = (ins[15:12] == 4'hF) && (ins[7:0] == 8'h55 || ins[7:0] == 8'h65);
    if (multi) begin
      for (int k = 0; k <= int'(ins[11:8]); k++) begin
        if (k == abort_at) return;
        noise();
        step(mk(1'b0, 12'h0, m_pc, ins, 4'(k), 1'b0, m_err, 1'b0));
      end
    end
    if (m_halt) begin
      repeat (3) begin
        noise();
        step(mk(1'b0, 12'h0, m_pc, 16'h0, 4'h0, 1'b0, 1'b1, 1'b1));
      end
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] r;
    case ($urandom_range(0, 5))
      0: r = 16'h00EE;
      1: r = {4'h2, 12'($urandom)};
      2: r = {4'hF, 4'($urandom), ($urandom_range(0, 1) != 0) ? 8'h55 : 8'h65};
      default: r = 16'($urandom);
    endcase
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    #1;
    // jump requested by the CPU in the execute slot
    do_reset();
    run_instr(16'h1234, 0, 1'b1, 12'h234, -1);
    check("jump_fetch_addr", 32'(mem_addr), 32'h234);

    // call then return
    do_reset();
    run_instr(16'h2300, 0, 1'b0, 12'h0, -1);
    check("call_fetch_addr", 32'(mem_addr), 32'h300);
    run_instr(16'h00EE, 0, 1'b1, 12'h555, -1);
    check("ret_fetch_addr", 32'(mem_addr), 32'h202);

    // multicycle transfer, x=3
    do_reset();
    run_instr(16'hF355, 0, 1'b0, 12'h0, -1);
    check("multi_next_addr", 32'(mem_addr), 32'h202);
    check("multi_control_clear", 32'(CONTROL), 32'h0);

    // 17 nested calls overflow a 16-entry stack
    do_reset();
    for (int i = 0; i < 17; i++) run_instr({4'h2, 12'(12'h400 + 16 * i)}, 0, 1'b0, 12'h0, -1);
    check("overflow_error", 32'(stack_error), 32'h1);
    check("overflow_halted", 32'(halted), 32'h1);

    // return with an empty stack
    do_reset();
    run_instr(16'h00EE, 0, 1'b0, 12'h0, -1);
    check("underflow_error", 32'(stack_error), 32'h1);
    check("underflow_halted", 32'(halted), 32'h1);

    // fetch across the top of the address space
    do_reset();
    run_instr(16'h1FFE, 0, 1'b1, 12'hFFE, -1);
    run_instr(16'h6A05, 0, 1'b0, 12'h0, -1);
    check("wrap_fetch_addr", 32'(mem_addr), 32'h000);

    // run dropped mid-fetch: instruction completes, then the block stalls
    do_reset();
    run_instr(16'h6A12, 2, 1'b0, 12'h0, -1);
    repeat (3) begin
      noise();
      step(mk(1'b1, m_pc, m_pc, 16'h0, 4'h0, 1'b0, m_err, 1'b0));
    end
    check("stall_instruction", 32'(instruction), 32'h0);
    run_instr(16'h7B01, 0, 1'b0, 12'h0, -1);

    // reset while CONTROL is mid-count
    run_instr(16'hF765, 0, 1'b0, 12'h0, 3);
    check("multi_control_before_reset", 32'(CONTROL), 32'h3);
    do_reset();

    // randomized instruction stream
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      run_instr(rand_instr(), 1, 1'($urandom_range(0, 1)), 12'($urandom), -1);
      if (m_halt) do_reset();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chip8_fetch_sequencer.md
Name: chip8_fetch_sequencer

Overview:
Instruction fetch and sequencing stage that sits directly upstream of the Chip8 CPU decode/execute block. It owns the program counter and the 16-entry call stack. It reads two bytes from program memory and presents one stable 16-bit instruction per execute slot. For the multicycle register/memory transfer instructions it steps the CONTROL counter. It also applies the PC writes that the CPU block requests.

Parameters:
PC_RESET, 12'h200, program counter value after reset
STACK_DEPTH, 16, call stack entries (power of two, at most 16)

Ports:
cpu_clk  in  1  single clock; all state updates on its rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
run  in  1  enable; when low, no new fetch is started
mem_addr  out  12  program memory read address (synchronous RAM, 1-cycle read latency)
mem_readdata  in  8  program memory read data
instruction  out  16  instruction presented to the CPU
CONTROL  out  4  multicycle step index to the CPU
PC_readdata  out  12  current PC to the CPU
PC_WE  in  1  CPU requests a PC write
PC_writedata  in  12  PC value from the CPU
exec_strobe  out  1  high for exactly one cycle per instruction, on its first execute cycle
stack_error  out  1  sticky; set on stack overflow or underflow
halted  out  1  high in state HALT

Behaviour:
- Reset values: PC=PC_RESET, sp=0, state=FETCH_HI, instruction=16'h0000, CONTROL=0, mem_addr=PC_RESET, exec_strobe=0, stack_error=0, halted=0. Stack contents are don't-care.
- instruction reads 16'h0000 in every state other than EXECUTE and MULTI. 16'h0000 causes no writes in the CPU.
- FETCH_HI: mem_addr=PC. If run=1, go to FETCH_LO; otherwise stay.
- FETCH_LO: mem_addr=PC+1 (12-bit, wraps 0xFFF→0x000). Latch mem_readdata into the high byte. Go to LATCH.
- LATCH: latch mem_readdata into the low byte. PC <= PC+2 (mod 4096). Go to EXECUTE.
- EXECUTE: one cycle. Drive instruction; exec_strobe=1; PC_readdata is the already-incremented PC. Next-PC priority at the cycle end:
  - 00EE: if sp=0, set stack_error and go to HALT. Otherwise sp <= sp-1 and PC <= stack[sp-1].
  - 2nnn: if sp=STACK_DEPTH, set stack_error and go to HALT. Otherwise stack[sp] <= PC, sp <= sp+1, PC <= nnn.
  - Otherwise, if PC_WE=1: PC <= PC_writedata.
  - In all other cases PC is unchanged.
  - Fx55/Fx65: go to MULTI with CONTROL=0. Everything else goes to FETCH_HI.
- MULTI: instruction is held. CONTROL increments by 1 each cycle from 0 up to x=instruction[11:8], so the state lasts x+1 cycles. PC_WE is ignored. After the CONTROL=x cycle, go to FETCH_HI with CONTROL=0.
- HALT: outputs are idle and halted=1. Only reset leaves HALT.
- run deassertion mid-instruction does not abort it: the current instruction completes, and the block then stalls in FETCH_HI.
- Throughput: 4 cycles per single-cycle instruction; 4+x+1 cycles for Fx55/Fx65.
- Reset asserted mid-operation returns all state to reset values asynchronously. No partial stack push is retained.

Test Plan:
- Memory 0x200=12, 0x201=34, run=1 from reset → mem_addr goes 0x200, then 0x201. instruction=0x1234 with exec_strobe in cycle 4. The CPU drives PC_WE with 0x234, and the next fetch address is 0x234.
- 0x200: 2300; 0x300: 00EE → after the call, sp=1, stack[0]=0x202, next fetch at 0x300. After the return, sp=0 and next fetch at 0x202.
- F355 at 0x200 → CONTROL=0,1,2,3 on four consecutive cycles with instruction held at 0xF355. The next fetch is at 0x202 and CONTROL=0.
- 17 nested 2nnn calls → stack_error=1 and halted=1 on the 17th, with sp=16. A 00EE from reset → stack_error=1.
- PC preloaded to 0xFFE via 1FFE → byte reads at 0xFFE and 0xFFF. The next fetch address is 0x000.
- run dropped during FETCH_LO → the instruction completes, the block stalls in FETCH_HI with instruction=0. Reset asserted in MULTI → CONTROL=0 and PC=0x200 immediately.
